// File: rtl/awe_pkg.sv
// rtl/awe_pkg.sv - shared types and constants for the weight fetch engine
package awe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } awe_state_e;

    localparam int AWE_FIFO_DEPTH = 2;
    localparam int AWE_PTR_W      = 1;
    localparam int AWE_CNT_W      = 2;

endpackage

// File: rtl/awe_fetch_fifo.sv
// rtl/awe_fetch_fifo.sv - two-entry output FIFO holding weight word plus last flag
import awe_pkg::*;

module awe_fetch_fifo #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 push_last,
    input  logic                 pop,
    output logic [WIDTH-1:0]     head_data,
    output logic                 head_last,
    output logic [AWE_CNT_W-1:0] count
);

    logic [WIDTH:0]         mem [AWE_FIFO_DEPTH];
    logic [AWE_PTR_W-1:0]   wr_ptr;
    logic [AWE_PTR_W-1:0]   rd_ptr;
    logic [AWE_CNT_W-1:0]   count_q;

    assign head_data = mem[rd_ptr][WIDTH-1:0];
    assign head_last = mem[rd_ptr][WIDTH];
    assign count     = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < AWE_FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {push_last, push_data};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count_q <= count_q + AWE_CNT_W'(push) - AWE_CNT_W'(pop);
        end
    end

endmodule

// File: rtl/awe_weight_fetch.sv
// rtl/awe_weight_fetch.sv - burst reader from the weight table into a ready/valid stream
import awe_pkg::*;

module awe_weight_fetch #(
    parameter int WIDTH   = 32,
    parameter int W_DEPTH = 8,
    parameter int N_DEPTH = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [W_DEPTH-1:0] base_addr,
    input  logic [W_DEPTH:0]   num_words,
    input  logic               abort,
    output logic [W_DEPTH-1:0] ram_addr,
    input  logic [WIDTH-1:0]   ram_rdata,
    output logic               w_valid,
    input  logic               w_ready,
    output logic [WIDTH-1:0]   w_data,
    output logic               w_last,
    output logic               busy,
    output logic               done
);

    awe_state_e             state;
    logic [W_DEPTH-1:0]     addr_q;
    logic [W_DEPTH:0]       issue_rem;
    logic                   inflight;
    logic                   inflight_last;
    logic                   done_q;

    logic [AWE_CNT_W-1:0]   fifo_count;
    logic [WIDTH-1:0]       fifo_data;
    logic                   fifo_last;
    logic                   fifo_nonempty;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   pop;
    logic                   issue;
    logic [2:0]             occ;

    // An empty FIFO lets the returning read bypass straight to the output, which
    // is what gives the two-cycle start-to-valid latency.
    assign fifo_nonempty = (fifo_count != '0);
    assign w_valid       = fifo_nonempty | inflight;
    assign w_data        = fifo_nonempty ? fifo_data : (inflight ? ram_rdata : '0);
    assign w_last        = fifo_nonempty ? fifo_last : (inflight & inflight_last);
    assign pop           = w_valid & w_ready;
    assign fifo_pop      = pop & fifo_nonempty;
    assign fifo_push     = inflight & ~(pop & ~fifo_nonempty) & ~abort;

    assign occ   = 3'(fifo_count) + 3'(inflight) - 3'(pop);
    assign issue = (state == ST_FETCH) && !abort && (occ < 3'(AWE_FIFO_DEPTH));

    assign ram_addr = addr_q;
    assign busy     = (state != ST_IDLE);
    assign done     = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            addr_q        <= '0;
            issue_rem     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q        <= 1'b0;
            inflight      <= issue;
            inflight_last <= issue && (issue_rem == (W_DEPTH+1)'(1));
            if (abort) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            if (num_words == '0) begin
                                done_q <= 1'b1;
                            end else begin
                                addr_q    <= base_addr;
                                issue_rem <= num_words;
                                state     <= ST_FETCH;
                            end
                        end
                    end
                    ST_FETCH: begin
                        if (issue) begin
                            addr_q    <= (addr_q == W_DEPTH'(N_DEPTH - 1)) ? '0 : addr_q + 1'b1;
                            issue_rem <= issue_rem - 1'b1;
                            if (issue_rem == (W_DEPTH+1)'(1)) begin
                                state <= ST_DRAIN;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (pop && w_last) begin
                            done_q <= 1'b1;
                            state  <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    awe_fetch_fifo #(
        .WIDTH(WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (abort),
        .push      (fifo_push),
        .push_data (ram_rdata),
        .push_last (inflight_last),
        .pop       (fifo_pop),
        .head_data (fifo_data),
        .head_last (fifo_last),
        .count     (fifo_count)
    );

endmodule

// File: doc/awe_weight_fetch.md
AWE_WEIGHT_FETCH -- requirements
Module: awe_weight_fetch

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning weight word width; SHALL equal the weight table WIDTH.
REQ-002 SHALL have parameter W_DEPTH, default 8, meaning table address width.
REQ-003 SHALL have parameter N_DEPTH, default 256, meaning table depth; SHALL equal 2**W_DEPTH.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-006 SHALL have port start, input, 1, meaning a one-cycle request to begin a burst.
REQ-007 SHALL have port base_addr, input, W_DEPTH, meaning the first table address, sampled when start is accepted.
REQ-008 SHALL have port num_words, input, W_DEPTH+1, meaning the burst length 0..N_DEPTH, sampled when start is accepted.
REQ-009 SHALL have port abort, input, 1, meaning a synchronous burst cancel.
REQ-010 SHALL have port ram_addr, output, W_DEPTH, meaning the read address to the table's port B (table web tied low).
REQ-011 SHALL have port ram_rdata, input, WIDTH, meaning table doutb, valid one cycle after ram_addr.
REQ-012 SHALL have port w_valid, output, 1, meaning the output word is valid.
REQ-013 SHALL have port w_ready, input, 1, meaning the consumer accepts the word.
REQ-014 SHALL have port w_data, output, WIDTH, meaning the weight word.
REQ-015 SHALL have port w_last, output, 1, meaning the final word of the burst.
REQ-016 SHALL have port busy, output, 1, meaning the FSM is not IDLE.
REQ-017 SHALL have port done, output, 1, meaning a one-cycle pulse at burst completion.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH (issuing reads) and DRAIN (all reads issued, FIFO not yet empty).
REQ-019 In IDLE, start=1 with num_words>0 SHALL latch base_addr and num_words and go to FETCH next cycle.
REQ-020 In IDLE, start=1 with num_words=0 SHALL pulse done next cycle, stay IDLE and produce no w_valid.
REQ-021 A start asserted while busy=1 SHALL be ignored.
REQ-022 A read is issued in a cycle when the next address is driven on ram_addr and the in-flight flag is set; the returning ram_rdata SHALL be written into the 2-entry output FIFO on the following cycle.
REQ-023 A read SHALL be issued only when (fifo_count + inflight - pop) < 2, where pop = w_valid & w_ready; the FIFO SHALL never overflow.
REQ-024 Issued addresses SHALL be base_addr + i modulo N_DEPTH for i = 0..num_words-1, wrapping from N_DEPTH-1 to 0.
REQ-025 With w_ready held at 1, the block SHALL sustain one word per cycle; the first w_valid SHALL rise 2 cycles after start.
REQ-026 w_data and w_last SHALL be held stable while w_valid=1 and w_ready=0.
REQ-027 w_last SHALL be 1 exactly on word num_words-1.
REQ-028 After the last issue, the FSM SHALL go FETCH->DRAIN; on the handshake of the w_last word, done SHALL pulse the next cycle and the FSM SHALL return to IDLE.
REQ-029 abort in any state SHALL flush the FIFO, drop any in-flight read and clear w_valid next cycle, go to IDLE, and SHALL NOT pulse done.
REQ-030 start and abort in the same cycle SHALL resolve to abort.
REQ-031 The burst counters SHALL be W_DEPTH+1 bits wide so that num_words=N_DEPTH reads every entry exactly once.

Reset
REQ-032 On rst_n=0: state=IDLE, ram_addr=0, w_valid=0, w_data=0, w_last=0, busy=0, done=0, FIFO empty, inflight=0.
REQ-033 Reset asserted mid-burst SHALL discard the burst; after release the block SHALL accept a new start.

Structure
REQ-034 The FSM state enum and the FIFO depth constant (2) SHALL reside in the shared package awe_pkg.
REQ-035 The 2-entry FIFO SHALL be the sub-module awe_fetch_fifo (data plus last bit, count output); the rest stays in awe_weight_fetch.

Verification
REQ-036 Table preloaded with ram[i]=i; base_addr=0x10, num_words=4, w_ready=1 -> w_data 0x10,0x11,0x12,0x13 on consecutive cycles, w_last on 0x13, done one cycle later.
REQ-037 base_addr=0xFE, num_words=4 -> w_data 0xFE,0xFF,0x00,0x01.
REQ-038 num_words=8, w_ready toggling 1/0 each cycle -> all 8 words in order, none duplicated or lost, ram_addr never more than 2 ahead of the consumer.
REQ-039 num_words=0 -> done pulse next cycle, w_valid stays 0; num_words=256 -> 256 words, w_last on the 256th.
REQ-040 abort after 3 handshakes of a 10-word burst -> w_valid=0 next cycle, no done pulse; a following start with base_addr=0, num_words=2 -> 0x00,0x01.
REQ-041 rst_n pulsed low mid-burst -> all outputs 0 immediately; start after release behaves as REQ-036.
